stage_if_fetch: RTL and testbench
=================================

// Module: stage_if_fetch
// PURPOSE
//  Instruction-fetch stage upstream of StageID: PC register, next-PC select (branch/jump/seq),
//  local instruction memory with load port, IF/ID pipeline latch. Feeds StageID fields
//  (opCode, rs, rt, rd, immediate, Function, inPc) and takes back PCSrc/outAddBranch/Jump/stall.
// PARAMETERS
//  IMEM_ADDR_W  8       word-address width; memory holds 2**IMEM_ADDR_W 32-bit words
//  RESET_PC     32'h0   PC value loaded on reset (bits[1:0] forced 0)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst_n          in   1   synchronous reset, active low
//  inStall        in   1   hazard stall from hazard unit: hold PC and IF/ID latch
//  PCSrc          in   1   branch taken (resolved in ID)
//  inAddBranch    in   32  branch target (StageID outAddBranch)
//  Jump           in   1   jump decoded in ID
//  inJumpTarget   in   32  jump target, full byte address
//  imemWe         in   1   instruction-memory write enable (program load)
//  imemAddr       in   IMEM_ADDR_W  word address for load
//  imemData       in   32  word to load
//  outPc          out  32  current fetch PC (debug)
//  outPcLatch     out  32  latched PC+4 of instruction in IF/ID (StageID inPc)
//  outInstruction out  32  latched instruction word
//  opCode         out  6   outInstruction[31:26]
//  rs / rt / rd   out  5   [25:21] / [20:16] / [15:11]
//  immediate      out  16  [15:0]
//  Function       out  6   [5:0]
//  outValid       out  1   IF/ID holds a real (non-bubble) instruction
//  halted         out  1   fetch halted (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): PC<=RESET_PC; outPcLatch<=0; outInstruction<=0 (NOP);
//   outValid<=0; halted<=0. Memory contents NOT cleared by reset.
//  Fetch read: combinational, word = mem[PC[IMEM_ADDR_W+1:2]]; PC beyond depth -> 32'h0.
//  Next PC priority (evaluated only when inStall=0): PCSrc -> inAddBranch; else Jump ->
//   inJumpTarget; else PC+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0). Targets: bits[1:0] forced 0.
//  inStall=1: PC, outPcLatch, outInstruction, outValid all hold; PCSrc/Jump ignored
//   (ID suppresses them under stall).
//  Normal cycle (stall=0, no redirect): IF/ID <= {PC+4, fetched word}, outValid<=1.
//  Redirect (stall=0, PCSrc|Jump): PC<=target; IF/ID loaded with bubble: instr 0,
//   outPcLatch 0, outValid 0 (one-slot flush of wrong-path fetch).
//  Latency: word at PC visible on outInstruction 1 cycle after PC presented.
//  Load port: imemWe writes mem[imemAddr] at edge, independent of stall/reset; a fetch of
//   the same address in the same cycle returns old contents; new word from next cycle.
//  Field outputs are pure slices of outInstruction (no extra register).
// CONFIGURATION
//  HALT_DETECT_EN defined: fetched word 32'hFFFF_FFFF (opcode 6'h3F) with stall=0 and no
//   redirect -> PC holds, IF/ID loaded with bubble, halted<=1 sticky until reset; further
//   PCSrc/Jump ignored while halted. Redirect in halt-fetch cycle wins (no halt).
//  Not defined: 32'hFFFF_FFFF fetched as ordinary instruction; halted tied 0.
// TESTING
//  Reset then run, mem[0..3]=A,B,C,D -> outInstruction A,B,C on cycles 1,2,3; outPcLatch 4,8,12.
//  inStall=1 for 2 cycles at PC=8 -> PC stays 8, outInstruction/outPcLatch unchanged, resumes C.
//  PCSrc=1, inAddBranch=32'h40 at PC=12 -> next PC 0x40, outValid=0 one cycle, then mem[16].
//  PCSrc=1 and Jump=1 same cycle (targets 0x20, 0x80) -> PC=0x20; inJumpTarget=0x83 -> PC=0x80.
//  imemWe to addr 5 while PC=0x14 -> old word latched; refetch after branch to 0x14 gives new.
//  HALT_DETECT_EN: mem[2]=32'hFFFF_FFFF -> halted=1 after PC=8 fetch, PC stays 8, outValid=0.

Source files
------------

// File: rtl/stage_if_fetch.sv
// ---------------------------------------------------------------------------
// stage_if_fetch
//
// Instruction-fetch stage that sits in front of StageID. Holds the program
// counter, selects the next PC (branch / jump / sequential), owns a local
// word-addressed instruction memory with a program-load port, and registers
// the fetched word plus PC+4 into the IF/ID pipeline latch.
//
// Build option:
//   HALT_DETECT_EN  when defined, fetching 32'hFFFF_FFFF (with no stall and no
//                   redirect) freezes the PC, inserts a bubble and raises a
//                   sticky 'halted' flag that only reset clears. When not
//                   defined, that word is fetched like any other instruction
//                   and 'halted' stays 0.
//
// Parameters:
//   IMEM_ADDR_W     word-address width; memory holds 2**IMEM_ADDR_W words
//   RESET_PC        PC loaded on reset (bits [1:0] forced to 0)
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst_n           synchronous reset, active low
//   inStall         hazard stall: hold PC and IF/ID latch
//   PCSrc           branch taken (resolved in ID)
//   inAddBranch     branch target byte address
//   Jump            jump decoded in ID
//   inJumpTarget    jump target byte address
//   imemWe          instruction-memory write enable (program load)
//   imemAddr        word address for the load port
//   imemData        word to load
//   outPc           current fetch PC
//   outPcLatch      PC+4 of the instruction held in IF/ID
//   outInstruction  instruction word held in IF/ID
//   opCode/rs/rt/rd/immediate/Function
//                   field slices of outInstruction
//   outValid        IF/ID holds a real instruction (not a bubble)
//   halted          fetch halted (HALT_DETECT_EN builds only)
// ---------------------------------------------------------------------------
module stage_if_fetch #(
    parameter int          IMEM_ADDR_W = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inStall,
    input  logic                   PCSrc,
    input  logic [31:0]            inAddBranch,
    input  logic                   Jump,
    input  logic [31:0]            inJumpTarget,
    input  logic                   imemWe,
    input  logic [IMEM_ADDR_W-1:0] imemAddr,
    input  logic [31:0]            imemData,
    output logic [31:0]            outPc,
    output logic [31:0]            outPcLatch,
    output logic [31:0]            outInstruction,
    output logic [5:0]             opCode,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [15:0]            immediate,
    output logic [5:0]             Function,
    output logic                   outValid,
    output logic                   halted
);

    localparam int          IMEM_DEPTH = 1 << IMEM_ADDR_W;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0] pcQ;
    logic [31:0] pcLatchQ;
    logic [31:0] instrQ;
    logic        validQ;
    logic        haltedQ;

    logic [31:0] pcNext;
    logic [31:0] pcLatchNext;
    logic [31:0] instrNext;
    logic        validNext;
    logic        haltedNext;

    logic [31:0] mem [0:IMEM_DEPTH-1];

    // -----------------------------------------------------------------------
    // Instruction memory: load port has no reset so a program survives a
    // pipeline reset. Read is asynchronous, so a same-cycle write to the
    // address being fetched is not yet visible (old word returned).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (imemWe) begin
            mem[imemAddr] <= imemData;
        end
    end

    logic                   pcInRange;
    logic [IMEM_ADDR_W-1:0] fetchIdx;
    logic [31:0]            fetchWord;

    assign fetchIdx = pcQ[IMEM_ADDR_W+1:2];

    // PC bits above the memory window must be zero for a hit; anything
    // beyond the array reads as a NOP.
    generate
        if (IMEM_ADDR_W < 30) begin : gRangeCheck
            assign pcInRange = (pcQ[31:IMEM_ADDR_W+2] == '0);
        end else begin : gNoRangeCheck
            assign pcInRange = 1'b1;
        end
    endgenerate

    assign fetchWord = pcInRange ? mem[fetchIdx] : 32'h0;

    // -----------------------------------------------------------------------
    // Halt detection
    // -----------------------------------------------------------------------
    logic haltHit;

`ifdef HALT_DETECT_EN
    assign haltHit = (fetchWord == HALT_WORD);
`else
    assign haltHit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state selection
    // -----------------------------------------------------------------------
    logic [31:0] pcPlus4;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;

    assign pcPlus4      = pcQ + 32'd4;
    assign branchTarget = inAddBranch  & WORD_MASK;
    assign jumpTarget   = inJumpTarget & WORD_MASK;

    always_comb begin
        pcNext      = pcQ;
        pcLatchNext = pcLatchQ;
        instrNext   = instrQ;
        validNext   = validQ;
        haltedNext  = haltedQ;

        if (!inStall) begin
            if (haltedQ) begin
                // Frozen: keep feeding bubbles, ignore redirects.
                pcLatchNext = 32'h0;
                instrNext   = 32'h0;
                validNext   = 1'b0;
            end else if (PCSrc || Jump) begin
                // Branch beats jump. The word fetched this cycle is on the
                // wrong path, so it is replaced by a bubble.
                pcNext      = PCSrc ? branchTarget : jumpTarget;
                pcLatchNext = 32'h0;
                instrNext   = 32'h0;
                validNext   = 1'b0;
            end else if (haltHit) begin
                pcLatchNext = 32'h0;
                instrNext   = 32'h0;
                validNext   = 1'b0;
                haltedNext  = 1'b1;
            end else begin
                pcNext      = pcPlus4;
                pcLatchNext = pcPlus4;
                instrNext   = fetchWord;
                validNext   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcQ      <= RESET_PC & WORD_MASK;
            pcLatchQ <= 32'h0;
            instrQ   <= 32'h0;
            validQ   <= 1'b0;
            haltedQ  <= 1'b0;
        end else begin
            pcQ      <= pcNext;
            pcLatchQ <= pcLatchNext;
            instrQ   <= instrNext;
            validQ   <= validNext;
            haltedQ  <= haltedNext;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign outPc          = pcQ;
    assign outPcLatch     = pcLatchQ;
    assign outInstruction = instrQ;
    assign outValid       = validQ;
    assign halted         = haltedQ;

    assign opCode    = instrQ[31:26];
    assign rs        = instrQ[25:21];
    assign rt        = instrQ[20:16];
    assign rd        = instrQ[15:11];
    assign immediate = instrQ[15:0];
    assign Function  = instrQ[5:0];

endmodule

// File: tb/tb_stage_if_fetch.sv
module tb_stage_if_fetch;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inStall;
    logic          PCSrc;
    logic [31:0]   inAddBranch;
    logic          Jump;
    logic [31:0]   inJumpTarget;
    logic          imemWe;
    logic [AW-1:0] imemAddr;
    logic [31:0]   imemData;
    logic [31:0]   outPc;
    logic [31:0]   outPcLatch;
    logic [31:0]   outInstruction;
    logic [5:0]    opCode;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [15:0]   immediate;
    logic [5:0]    Function;
    logic          outValid;
    logic          halted;

    stage_if_fetch #(.IMEM_ADDR_W(AW), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inStall        (inStall),
        .PCSrc          (PCSrc),
        .inAddBranch    (inAddBranch),
        .Jump           (Jump),
        .inJumpTarget   (inJumpTarget),
        .imemWe         (imemWe),
        .imemAddr       (imemAddr),
        .imemData       (imemData),
        .outPc          (outPc),
        .outPcLatch     (outPcLatch),
        .outInstruction (outInstruction),
        .opCode         (opCode),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .immediate      (immediate),
        .Function       (Function),
        .outValid       (outValid),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic [31:0] latch;
        logic [31:0] instr;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    int   stepNo = 0;

    // Monitor: after each rising edge the stimulus queues what the IF/ID
    // outputs must show; compare on the following falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                exp_t e;
                logic [31:0] ei;
                e  = expQ.pop_front();
                ei = e.instr;
                checks++;
                if (outPc === e.pc && outPcLatch === e.latch && outInstruction === e.instr &&
                    outValid === e.valid && halted === e.halt) begin
                    passes++;
                end else begin
                    $display("FAIL step%0d state: got pc=%h latch=%h instr=%h valid=%b halted=%b, want pc=%h latch=%h instr=%h valid=%b halted=%b",
                             e.tag, outPc, outPcLatch, outInstruction, outValid, halted,
                             e.pc, e.latch, e.instr, e.valid, e.halt);
                end
                checks++;
                if (opCode === ei[31:26] && rs === ei[25:21] && rt === ei[20:16] &&
                    rd === ei[15:11] && immediate === ei[15:0] && Function === ei[5:0]) begin
                    passes++;
                end else begin
                    $display("FAIL step%0d fields: got op=%h rs=%h rt=%h rd=%h imm=%h fn=%h, want slices of %h",
                             e.tag, opCode, rs, rt, rd, immediate, Function, ei);
                end
            end
        end
    end

    task automatic step(input logic rstN, input logic stall,
                        input logic br, input logic [31:0] brT,
                        input logic jmp, input logic [31:0] jT,
                        input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                        input logic [31:0] ePc, input logic [31:0] eLatch,
                        input logic [31:0] eInstr, input logic eValid, input logic eHalt);
        exp_t e;
        rst_n        = rstN;
        inStall      = stall;
        PCSrc        = br;
        inAddBranch  = brT;
        Jump         = jmp;
        inJumpTarget = jT;
        imemWe       = we;
        imemAddr     = wa;
        imemData     = wd;
        @(posedge clk);
        stepNo++;
        e.tag   = stepNo;
        e.pc    = ePc;
        e.latch = eLatch;
        e.instr = eInstr;
        e.valid = eValid;
        e.halt  = eHalt;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    // Shorthands for common step shapes.
    task automatic run(input logic [31:0] ePc, input logic [31:0] eLatch, input logic [31:0] eInstr);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ePc, eLatch, eInstr, 1, 0);
    endtask

    task automatic bubble(input logic br, input logic [31:0] brT, input logic jmp,
                          input logic [31:0] jT, input logic [31:0] ePc);
        step(1, 0, br, brT, jmp, jT, 0, 0, 0, ePc, 32'h0, 32'h0, 0, 0);
    endtask

    initial begin
        logic [31:0] w;
        // Program load under reset: mem[i] = 0x1000_0000 + i, with a few
        // special words. Every reset cycle must show the reset state.
        for (int i = 0; i < 64; i++) begin
            if (i == 1)       w = 32'h8CA6_39C5;
            else if (i == 40) w = 32'hFFFF_FFFF;
            else              w = 32'h1000_0000 + i;
            step(0, 0, 0, 0, 0, 0, 1, i[AW-1:0], w, 32'h0, 32'h0, 32'h0, 0, 0);
        end

        // Sequential fetch.
        run(32'h4, 32'h4, 32'h1000_0000);
        run(32'h8, 32'h8, 32'h8CA6_39C5);
        // Two-cycle stall at PC=8.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h8, 32'h8, 32'h8CA6_39C5, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h8, 32'h8, 32'h8CA6_39C5, 1, 0);
        run(32'hC,  32'hC,  32'h1000_0002);
        run(32'h10, 32'h10, 32'h1000_0003);
        // Taken branch -> bubble, then target word.
        bubble(1, 32'h40, 0, 0, 32'h40);
        run(32'h44, 32'h44, 32'h1000_0010);
        // Branch beats jump; low target bits forced to zero.
        bubble(1, 32'h22, 1, 32'h80, 32'h20);
        bubble(0, 32'h0, 1, 32'h83, 32'h80);
        run(32'h84, 32'h84, 32'h1000_0020);
        // Stall masks a concurrent branch.
        step(1, 1, 1, 32'h100, 0, 0, 0, 0, 0, 32'h84, 32'h84, 32'h1000_0020, 1, 0);
        // Write to the word being fetched: old word first, new word on refetch.
        bubble(1, 32'h14, 0, 0, 32'h14);
        step(1, 0, 0, 0, 0, 0, 1, 8'd5, 32'hDEAD_BEEF, 32'h18, 32'h18, 32'h1000_0005, 1, 0);
        bubble(1, 32'h14, 0, 0, 32'h14);
        run(32'h18, 32'h18, 32'hDEAD_BEEF);
        // Load port works during stall.
        step(1, 1, 0, 0, 0, 0, 1, 8'd6, 32'h1234_5678, 32'h18, 32'h18, 32'hDEAD_BEEF, 1, 0);
        run(32'h1C, 32'h1C, 32'h1234_5678);
        // Beyond memory depth reads 0.
        bubble(0, 0, 1, 32'h400, 32'h400);
        run(32'h404, 32'h404, 32'h0);
        // PC wrap at top of address space.
        bubble(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        run(32'h0, 32'h0, 32'h0);
        run(32'h4, 32'h4, 32'h1000_0000);
        // Halt word at 0xA0.
        bubble(0, 0, 1, 32'hA0, 32'hA0);
`ifdef HALT_DETECT_EN
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA0, 32'h0, 32'h0, 0, 1);
        step(1, 0, 0, 0, 1, 32'h0, 0, 0, 0, 32'hA0, 32'h0, 32'h0, 0, 1);
`else
        run(32'hA4, 32'hA4, 32'hFFFF_FFFF);
        run(32'hA8, 32'hA8, 32'h1000_0029);
`endif
        // Reset clears halt/pipeline but keeps memory.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        bubble(0, 0, 1, 32'hA0, 32'hA0);
        // Redirect in the halt-fetch cycle wins.
        bubble(0, 0, 1, 32'h10, 32'h10);
        run(32'h14, 32'h14, 32'h1000_0004);
        run(32'h18, 32'h18, 32'hDEAD_BEEF);

        begin
            int budget = 20;
            while (expQ.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (expQ.size() > 0) begin
                checks++;
                $display("FAIL drain: got %0d pending expectations, want 0", expQ.size());
            end
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion by 200000, want finish");
        $fatal(1, "timeout");
    end

endmodule
